// File: rtl/conv_mac_unit.sv
// conv_mac_unit
//   Pipelined multiply-accumulate stage for a KxK sliding-window convolution.
//   Each accepted window is multiplied element-wise with a programmable kernel,
//   summed with a bias, rescaled from the product fixed-point format back to
//   the pixel format, saturated, optionally ReLU-clamped and emitted together
//   with its output coordinates.
//
//   Pipeline (window accepted at edge T):
//     edge T   : stage 1 registers the K*K products and a copy of the bias
//     edge T+1 : stage 2 registers the accumulated sum
//     edge T+2 : stage 3 registers the shifted / saturated / ReLU result
//     edge T+3 : output register drives pixel_out, pixel_valid, out_x/out_y
//
//   Handshake: window_valid qualifies window_in for one cycle; there is no
//   backpressure, every valid window produces exactly one pixel_valid cycle
//   unless a frame_start or rst flushes it first.
//
// Ports
//   clk, rst      : clock, asynchronous active-high reset
//   window_in     : flattened window, element (i,j) at
//                   [(K*K-(i*K+j))*DATA_WIDTH-1 -: DATA_WIDTH]
//   window_valid  : window_in valid this cycle
//   frame_start   : flushes in-flight pixels and restarts the coordinates
//   w_we/w_addr/w_data : coefficient write (0..K*K-1 weight, K*K bias)
//   pixel_out     : result pixel
//   pixel_valid   : pixel_out valid
//   out_x, out_y  : coordinates of pixel_out
//   frame_done    : last pixel of a frame
//   busy          : any internal stage holds a valid window

module conv_mac_unit #(
    parameter int DATA_WIDTH  = 16,
    parameter int KERNEL_SIZE = 3,
    parameter int IMG_WIDTH   = 32,
    parameter int IMG_HEIGHT  = 32,
    parameter int FRAC_BITS   = 8,
    parameter int RELU_EN     = 1
) (
    input  logic                                                clk,
    input  logic                                                rst,
    input  logic [KERNEL_SIZE*KERNEL_SIZE*DATA_WIDTH-1:0]       window_in,
    input  logic                                                window_valid,
    input  logic                                                frame_start,
    input  logic                                                w_we,
    input  logic [$clog2(KERNEL_SIZE*KERNEL_SIZE+1)-1:0]        w_addr,
    input  logic [DATA_WIDTH-1:0]                               w_data,
    output logic [DATA_WIDTH-1:0]                               pixel_out,
    output logic                                                pixel_valid,
    output logic [$clog2(IMG_WIDTH)-1:0]                        out_x,
    output logic [$clog2(IMG_HEIGHT)-1:0]                       out_y,
    output logic                                                frame_done,
    output logic                                                busy
);

    localparam int KK    = KERNEL_SIZE * KERNEL_SIZE;
    localparam int DW    = DATA_WIDTH;
    localparam int AW    = $clog2(KK + 1);
    localparam int XW    = $clog2(IMG_WIDTH);
    localparam int YW    = $clog2(IMG_HEIGHT);
    localparam int PW    = 2 * DW;
    // One guard bit on top of log2(K*K) growth keeps the bias term from
    // overflowing the sum even when every product is at its extreme.
    localparam int ACC_W = 2 * DW + $clog2(KK) + 1;

    localparam logic [DW-1:0] PIX_MAX = {1'b0, {(DW-1){1'b1}}};
    localparam logic [DW-1:0] PIX_MIN = {1'b1, {(DW-1){1'b0}}};
    localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-DW+1){1'b0}}, {(DW-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SAT_MIN = ~SAT_MAX;

    // ------------------------------------------------------------------
    // Coefficient file
    // ------------------------------------------------------------------
    logic signed [DW-1:0] weight_q [KK];
    logic signed [DW-1:0] weight_d [KK];
    logic signed [DW-1:0] bias_coef_q;
    logic signed [DW-1:0] bias_coef_d;

    always_comb begin
        for (int k = 0; k < KK; k++) begin
            weight_d[k] = weight_q[k];
        end
        bias_coef_d = bias_coef_q;
        if (w_we) begin
            for (int k = 0; k < KK; k++) begin
                if (w_addr == AW'(k)) begin
                    weight_d[k] = w_data;
                end
            end
            if (w_addr == AW'(KK)) begin
                bias_coef_d = w_data;
            end
        end
    end

    // ------------------------------------------------------------------
    // Stage 1: multiply. The bias is captured alongside the products so a
    // bias write in the acceptance cycle cannot leak into this window.
    // ------------------------------------------------------------------
    logic signed [DW-1:0] win_elem [KK];
    logic signed [PW-1:0] prod_q   [KK];
    logic signed [PW-1:0] prod_d   [KK];
    logic signed [DW-1:0] bias_s1_q;
    logic signed [DW-1:0] bias_s1_d;
    logic                 mul_vld_q;
    logic                 mul_vld_d;

    always_comb begin
        for (int k = 0; k < KK; k++) begin
            win_elem[k] = window_in[(KK-k)*DW-1 -: DW];
            prod_d[k]   = prod_q[k];
            if (window_valid) begin
                prod_d[k] = PW'(win_elem[k]) * PW'(weight_q[k]);
            end
        end
        bias_s1_d = window_valid ? bias_coef_q : bias_s1_q;
        // A window arriving with frame_start belongs to the new frame.
        mul_vld_d = window_valid;
    end

    // ------------------------------------------------------------------
    // Stage 2: accumulate products plus bias aligned to product scale
    // ------------------------------------------------------------------
    logic signed [ACC_W-1:0] acc_q;
    logic signed [ACC_W-1:0] acc_d;
    logic signed [ACC_W-1:0] acc_sum;
    logic                    acc_vld_q;
    logic                    acc_vld_d;

    always_comb begin
        acc_sum = ACC_W'(bias_s1_q) <<< FRAC_BITS;
        for (int k = 0; k < KK; k++) begin
            acc_sum = acc_sum + ACC_W'(prod_q[k]);
        end
        acc_d     = mul_vld_q ? acc_sum : acc_q;
        acc_vld_d = mul_vld_q & ~frame_start;
    end

    // ------------------------------------------------------------------
    // Stage 3: rescale (floor), saturate, optional ReLU
    // ------------------------------------------------------------------
    logic signed [ACC_W-1:0] shifted;
    logic        [DW-1:0]    post_res;
    logic        [DW-1:0]    post_q;
    logic        [DW-1:0]    post_d;
    logic                    post_vld_q;
    logic                    post_vld_d;

    always_comb begin
        shifted = acc_q >>> FRAC_BITS;
        if (shifted > SAT_MAX) begin
            post_res = PIX_MAX;
        end else if (shifted < SAT_MIN) begin
            post_res = PIX_MIN;
        end else begin
            post_res = shifted[DW-1:0];
        end
        if ((RELU_EN != 0) && post_res[DW-1]) begin
            post_res = '0;
        end
        post_d     = acc_vld_q ? post_res : post_q;
        post_vld_d = acc_vld_q & ~frame_start;
    end

    // ------------------------------------------------------------------
    // Output register and coordinate counters. cnt_x/cnt_y hold the
    // position the next emitted pixel will carry.
    // ------------------------------------------------------------------
    logic [DW-1:0] pixel_out_q,   pixel_out_d;
    logic          pixel_valid_q, pixel_valid_d;
    logic [XW-1:0] out_x_q,       out_x_d;
    logic [YW-1:0] out_y_q,       out_y_d;
    logic          frame_done_q,  frame_done_d;
    logic [XW-1:0] cnt_x_q,       cnt_x_d;
    logic [YW-1:0] cnt_y_q,       cnt_y_d;
    logic          x_last;
    logic          y_last;
    logic          emit;

    always_comb begin
        x_last = (cnt_x_q == XW'(IMG_WIDTH - 1));
        y_last = (cnt_y_q == YW'(IMG_HEIGHT - 1));
        // A pixel leaving stage 3 in a frame_start cycle is discarded.
        emit   = post_vld_q & ~frame_start;

        pixel_out_d   = pixel_out_q;
        out_x_d       = out_x_q;
        out_y_d       = out_y_q;
        pixel_valid_d = emit;
        frame_done_d  = emit & x_last & y_last;
        cnt_x_d       = cnt_x_q;
        cnt_y_d       = cnt_y_q;

        if (frame_start) begin
            cnt_x_d = '0;
            cnt_y_d = '0;
        end else if (emit) begin
            pixel_out_d = post_q;
            out_x_d     = cnt_x_q;
            out_y_d     = cnt_y_q;
            if (x_last) begin
                cnt_x_d = '0;
                cnt_y_d = y_last ? '0 : cnt_y_q + 1'b1;
            end else begin
                cnt_x_d = cnt_x_q + 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < KK; k++) begin
                weight_q[k] <= '0;
                prod_q[k]   <= '0;
            end
            bias_coef_q   <= '0;
            bias_s1_q     <= '0;
            mul_vld_q     <= 1'b0;
            acc_q         <= '0;
            acc_vld_q     <= 1'b0;
            post_q        <= '0;
            post_vld_q    <= 1'b0;
            pixel_out_q   <= '0;
            pixel_valid_q <= 1'b0;
            out_x_q       <= '0;
            out_y_q       <= '0;
            frame_done_q  <= 1'b0;
            cnt_x_q       <= '0;
            cnt_y_q       <= '0;
        end else begin
            for (int k = 0; k < KK; k++) begin
                weight_q[k] <= weight_d[k];
                prod_q[k]   <= prod_d[k];
            end
            bias_coef_q   <= bias_coef_d;
            bias_s1_q     <= bias_s1_d;
            mul_vld_q     <= mul_vld_d;
            acc_q         <= acc_d;
            acc_vld_q     <= acc_vld_d;
            post_q        <= post_d;
            post_vld_q    <= post_vld_d;
            pixel_out_q   <= pixel_out_d;
            pixel_valid_q <= pixel_valid_d;
            out_x_q       <= out_x_d;
            out_y_q       <= out_y_d;
            frame_done_q  <= frame_done_d;
            cnt_x_q       <= cnt_x_d;
            cnt_y_q       <= cnt_y_d;
        end
    end

    assign pixel_out   = pixel_out_q;
    assign pixel_valid = pixel_valid_q;
    assign out_x       = out_x_q;
    assign out_y       = out_y_q;
    assign frame_done  = frame_done_q;
    assign busy        = mul_vld_q | acc_vld_q | post_vld_q;

endmodule
